instr_boot_loader: RTL
======================

Name: instr_boot_loader

Overview:
- Writer side of the instruction flash ROM path.
- After reset, or on command, walks the combinational instruction ROM from address 0 upward.
- Copies each 16-bit word into the core's instruction RAM through a valid/ready write port.
- Holds the core in reset until the copy completes, and publishes a running 16-bit additive checksum so boot integrity can be checked.

Parameters:
- ADDR_WIDTH, 10: ROM/RAM word-address width.
- DATA_WIDTH, 16: instruction word width.
- LOAD_COUNT, 1024: number of words copied (1..2^ADDR_WIDTH).
- AUTO_BOOT, 1: 1 = start the copy automatically after reset; 0 = wait for Start.

Ports:
- clk  in  1  system clock, rising edge.
- async_rst  in  1  asynchronous, active-high reset.
- Start  in  1  single-cycle request to (re)start a copy.
- RomAddress  out  ADDR_WIDTH  address to the combinational instruction ROM.
- RomValue  in  DATA_WIDTH  ROM data; valid in the same cycle as RomAddress.
- WriteValid  out  1  instruction RAM write request.
- WriteAddress  out  ADDR_WIDTH  RAM write address.
- WriteData  out  DATA_WIDTH  RAM write data.
- WriteReady  in  1  RAM accepts the write this cycle.
- Busy  out  1  copy in progress.
- Done  out  1  copy complete; holds until the next start or reset.
- CoreHold  out  1  keeps the core in reset while 1.
- Checksum  out  DATA_WIDTH  sum of all words written so far, mod 2^DATA_WIDTH.

Behaviour:
- Reset is asynchronous and active-high. While asserted and on release:
  - State = IDLE, Count = 0, DataReg = 0, Checksum = 0.
  - WriteValid = 0, Busy = 0, Done = 0, CoreHold = 1.
  - RomAddress, WriteAddress and WriteData = 0.
- FSM states: IDLE, FETCH, WRITE, DONE.
- IDLE:
  - If AUTO_BOOT = 1, go to FETCH on the first clock after reset release.
  - Otherwise go to FETCH on the clock where Start = 1.
  - Leaving IDLE clears Count and Checksum.
- FETCH:
  - RomAddress = Count; Busy = 1.
  - At the clock edge, DataReg <= RomValue and the FSM goes to WRITE.
  - Exactly one cycle; no wait.
- WRITE:
  - WriteValid = 1, WriteAddress = Count, WriteData = DataReg, Busy = 1.
  - RomAddress keeps Count.
  - Write handshake completes on an edge with WriteValid & WriteReady. On that edge:
    - Checksum <= Checksum + DataReg (truncate to DATA_WIDTH).
    - If Count == LOAD_COUNT-1, go to DONE.
    - Otherwise Count <= Count+1 and go to FETCH.
  - If WriteReady = 0, stay in WRITE. WriteValid, WriteAddress and WriteData stay stable; no retraction.
- DONE:
  - Done = 1, CoreHold = 0, Busy = 0, WriteValid = 0. Checksum is frozen.
  - Start = 1 goes to FETCH with Count and Checksum cleared, Done = 0, CoreHold = 1 from the next cycle.
- CoreHold = 1 in every state except DONE. CoreHold and Busy are registered outputs decoded from state.
- Start while in FETCH or WRITE is ignored.
- Throughput: with WriteReady tied high, one word every 2 cycles.
  - Done rises 2*LOAD_COUNT+1 cycles after leaving IDLE (counting the IDLE→FETCH edge).
- Wrap-around:
  - With LOAD_COUNT = 2^ADDR_WIDTH, the last address is all-ones.
  - Count never increments past LOAD_COUNT-1, so there is no address wrap.
- Reset mid-copy:
  - Aborts immediately to the reset values.
  - The RAM may hold a partial image; the restarted copy overwrites it from address 0.
- No write is ever issued to addresses ≥ LOAD_COUNT.

Test Plan:
1. ROM model returns Address ^ 16'hA5A5, LOAD_COUNT=4, AUTO_BOOT=1, WriteReady=1 → writes (0,A5A5), (1,A5A4), (2,A5A7), (3,A5A6) in order; Done=1 and CoreHold=0 at cycle 9 after reset release; Checksum=16'h9696.
2. Same setup, WriteReady low for 3 cycles on the address-2 write → WriteValid/WriteAddress=2/WriteData=A5A7 held stable 4 cycles; no duplicate or skipped write; final Checksum=16'h9696.
3. AUTO_BOOT=0 → stays in IDLE with CoreHold=1 and no writes for 20 cycles. Start pulse → copy begins next cycle. Second Start pulse during WRITE → ignored; exactly 4 writes.
4. In DONE, pulse Start → Done falls and CoreHold rises next cycle; Checksum restarts from 0; identical 4-write sequence; final Checksum=16'h9696.
5. Assert async_rst mid-cycle during the address-1 WRITE → outputs return to reset values without waiting for a clock edge. After release, copy restarts at address 0 and completes normally.
6. LOAD_COUNT=1024 with an all-zero ROM → 1024 writes, last WriteAddress=10'h3FF, no write at address 0 after the first; Checksum=0; Done at cycle 2049.

Source files
------------

// File: rtl/instr_boot_loader_if.sv
// Instruction RAM write port: valid/ready handshake carrying one address/data word.
// master drives the request, slave (the RAM) returns WriteReady.
interface instr_boot_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16
);

  logic                  WriteValid;
  logic [ADDR_WIDTH-1:0] WriteAddress;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  WriteReady;

  modport master (
    output WriteValid,
    output WriteAddress,
    output WriteData,
    input  WriteReady
  );

  modport slave (
    input  WriteValid,
    input  WriteAddress,
    input  WriteData,
    output WriteReady
  );

endinterface

// File: rtl/instr_boot_loader.sv
// Copies the combinational instruction ROM into instruction RAM word by word, holding the
// core in reset until the image is complete and publishing a running additive checksum.
module instr_boot_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LOAD_COUNT = 1024,
  parameter int unsigned AUTO_BOOT  = 1
) (
  input  logic                  clk,
  input  logic                  async_rst,
  input  logic                  Start,
  output logic [ADDR_WIDTH-1:0] RomAddress,
  input  logic [DATA_WIDTH-1:0] RomValue,
  instr_boot_loader_if.master   wr,
  output logic                  Busy,
  output logic                  Done,
  output logic                  CoreHold,
  output logic [DATA_WIDTH-1:0] Checksum
);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StWrite,
    StDone
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(LOAD_COUNT - 1);
  localparam bit AutoBoot = (AUTO_BOOT != 0);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] checksum_q, checksum_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  core_hold_q, core_hold_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    data_d     = data_q;
    checksum_d = checksum_q;

    unique case (state_q)
      StIdle: begin
        if (AutoBoot || Start) begin
          state_d    = StFetch;
          count_d    = '0;
          checksum_d = '0;
        end
      end
      StFetch: begin
        data_d  = RomValue;
        state_d = StWrite;
      end
      StWrite: begin
        if (wr.WriteReady) begin
          checksum_d = checksum_q + data_q;
          // Count stops at the last address, so addresses never wrap.
          if (count_q == LastAddr) begin
            state_d = StDone;
          end else begin
            count_d = count_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StDone: begin
        if (Start) begin
          state_d    = StFetch;
          count_d    = '0;
          checksum_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Status flags are registered from the next state so they line up with state_q.
    busy_d      = (state_d == StFetch) || (state_d == StWrite);
    done_d      = (state_d == StDone);
    core_hold_d = (state_d != StDone);
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      data_q      <= '0;
      checksum_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      core_hold_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      data_q      <= data_d;
      checksum_q  <= checksum_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      core_hold_q <= core_hold_d;
    end
  end

  assign RomAddress      = count_q;
  assign wr.WriteValid   = (state_q == StWrite);
  assign wr.WriteAddress = count_q;
  assign wr.WriteData    = data_q;
  assign Busy            = busy_q;
  assign Done            = done_q;
  assign CoreHold        = core_hold_q;
  assign Checksum        = checksum_q;

endmodule
